// File: rtl/layer_pingpong_buffer_control.sv
// Ping-pong feature buffer controller between two CNN layers.
// Sequences former (writer) and next (reader) passes over two banks.
//
// Ports:
//   clock, reset            rising-edge clock, sync active-high reset
//   enable                  permits new layer passes to start
//   layer_former_done       former pass done level (rising edge used)
//   layer_next_done         next pass done level (rising edge used)
//   former_rden/wren        former layer RAM controls, bit0=a bit1=b
//   former_address_a/b      former layer RAM addresses
//   next_rden               next layer RAM read enables
//   next_address_a/b        next layer RAM addresses
//   bank0_* / bank1_*       routed per-bank RAM controls
//   layer_former_reset      one-cycle pulse before a former pass
//   layer_former_enable     high while the former pass runs
//   layer_next_reset        one-cycle pulse before a next pass
//   layer_next_enable       high while the next pass runs
//   next_bank_sel           bank the next layer reads (rd_ptr)
//   bank_full               bit i set: bank i holds a full map
module layer_pingpong_buffer_control #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  layer_former_done,
  input  logic                  layer_next_done,
  input  logic [1:0]            former_rden,
  input  logic [1:0]            former_wren,
  input  logic [ADDR_WIDTH-1:0] former_address_a,
  input  logic [ADDR_WIDTH-1:0] former_address_b,
  input  logic [1:0]            next_rden,
  input  logic [ADDR_WIDTH-1:0] next_address_a,
  input  logic [ADDR_WIDTH-1:0] next_address_b,
  output logic [1:0]            bank0_rden,
  output logic [1:0]            bank0_wren,
  output logic [ADDR_WIDTH-1:0] bank0_address_a,
  output logic [ADDR_WIDTH-1:0] bank0_address_b,
  output logic [1:0]            bank1_rden,
  output logic [1:0]            bank1_wren,
  output logic [ADDR_WIDTH-1:0] bank1_address_a,
  output logic [ADDR_WIDTH-1:0] bank1_address_b,
  output logic                  layer_former_enable,
  output logic                  layer_former_reset,
  output logic                  layer_next_enable,
  output logic                  layer_next_reset,
  output logic                  next_bank_sel,
  output logic [1:0]            bank_full
);

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_RESET = 2'd1,
    F_RUN   = 2'd2
  } f_state_t;

  typedef enum logic [1:0] {
    N_IDLE  = 2'd0,
    N_RESET = 2'd1,
    N_RUN   = 2'd2
  } n_state_t;

  f_state_t f_state, f_state_nx;
  n_state_t n_state, n_state_nx;

  logic       wr_ptr, wr_ptr_nx;
  logic       rd_ptr, rd_ptr_nx;
  logic [1:0] full_nx;
  logic       former_done_d;
  logic       next_done_d;
  logic       f_fin;
  logic       n_fin;

  // A pass finishes only on a done rising edge seen while running.
  assign f_fin = (f_state == F_RUN) &&
                 layer_former_done && !former_done_d;
  assign n_fin = (n_state == N_RUN) &&
                 layer_next_done && !next_done_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      f_state       <= F_IDLE;
      n_state       <= N_IDLE;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      bank_full     <= 2'b00;
      former_done_d <= 1'b0;
      next_done_d   <= 1'b0;
    end else begin
      f_state       <= f_state_nx;
      n_state       <= n_state_nx;
      wr_ptr        <= wr_ptr_nx;
      rd_ptr        <= rd_ptr_nx;
      bank_full     <= full_nx;
      former_done_d <= layer_former_done;
      next_done_d   <= layer_next_done;
    end
  end

  always_comb begin
    f_state_nx = f_state;
    wr_ptr_nx  = wr_ptr;
    unique case (f_state)
      F_IDLE: begin
        if (enable && !bank_full[wr_ptr])
          f_state_nx = F_RESET;
      end
      F_RESET: f_state_nx = F_RUN;
      F_RUN: begin
        if (f_fin) begin
          f_state_nx = F_IDLE;
          wr_ptr_nx  = ~wr_ptr;
        end
      end
      default: f_state_nx = F_IDLE;
    endcase
  end

  always_comb begin
    n_state_nx = n_state;
    rd_ptr_nx  = rd_ptr;
    unique case (n_state)
      N_IDLE: begin
        if (enable && bank_full[rd_ptr])
          n_state_nx = N_RESET;
      end
      N_RESET: n_state_nx = N_RUN;
      N_RUN: begin
        if (n_fin) begin
          n_state_nx = N_IDLE;
          rd_ptr_nx  = ~rd_ptr;
        end
      end
      default: n_state_nx = N_IDLE;
    endcase
  end

  // Set and clear always target different banks when both fire.
  always_comb begin
    full_nx = bank_full;
    if (f_fin) full_nx[wr_ptr] = 1'b1;
    if (n_fin) full_nx[rd_ptr] = 1'b0;
  end

  assign layer_former_reset  = (f_state == F_RESET);
  assign layer_former_enable = (f_state == F_RUN);
  assign layer_next_reset    = (n_state == N_RESET);
  assign layer_next_enable   = (n_state == N_RUN);
  assign next_bank_sel       = rd_ptr;

  // The reader never writes; idle banks see all-zero controls.
  always_comb begin
    bank0_rden      = 2'b00;
    bank0_wren      = 2'b00;
    bank0_address_a = '0;
    bank0_address_b = '0;
    bank1_rden      = 2'b00;
    bank1_wren      = 2'b00;
    bank1_address_a = '0;
    bank1_address_b = '0;
    if (n_state == N_RUN) begin
      if (!rd_ptr) begin
        bank0_rden      = next_rden;
        bank0_address_a = next_address_a;
        bank0_address_b = next_address_b;
      end else begin
        bank1_rden      = next_rden;
        bank1_address_a = next_address_a;
        bank1_address_b = next_address_b;
      end
    end
    if (f_state == F_RUN) begin
      if (!wr_ptr) begin
        bank0_rden      = former_rden;
        bank0_wren      = former_wren;
        bank0_address_a = former_address_a;
        bank0_address_b = former_address_b;
      end else begin
        bank1_rden      = former_rden;
        bank1_wren      = former_wren;
        bank1_address_a = former_address_a;
        bank1_address_b = former_address_b;
      end
    end
  end

  // Writer and reader must never share a bank.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!((f_state == F_RUN) && (n_state == N_RUN) &&
                (wr_ptr == rd_ptr)))
        else $error("bank conflict wr_ptr == rd_ptr");
    end
  end

endmodule

// File: tb/tb_layer_pingpong_buffer_control.sv
// Bench for layer_pingpong_buffer_control.
// Vector table with hand-derived expectations, checked via a queue.
module tb_layer_pingpong_buffer_control;

  localparam int AW = 9;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          fdone = 1'b0;
  logic          ndone = 1'b0;
  logic [1:0]    f_rden = '0, f_wren = '0, n_rden = '0;
  logic [AW-1:0] f_aa = '0, f_ab = '0, n_aa = '0, n_ab = '0;
  logic [1:0]    b0_rden, b0_wren, b1_rden, b1_wren;
  logic [AW-1:0] b0_aa, b0_ab, b1_aa, b1_ab;
  logic          f_en, f_rst, n_en, n_rst, sel;
  logic [1:0]    full;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  layer_pingpong_buffer_control #(.ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .layer_former_done(fdone), .layer_next_done(ndone),
    .former_rden(f_rden), .former_wren(f_wren),
    .former_address_a(f_aa), .former_address_b(f_ab),
    .next_rden(n_rden),
    .next_address_a(n_aa), .next_address_b(n_ab),
    .bank0_rden(b0_rden), .bank0_wren(b0_wren),
    .bank0_address_a(b0_aa), .bank0_address_b(b0_ab),
    .bank1_rden(b1_rden), .bank1_wren(b1_wren),
    .bank1_address_a(b1_aa), .bank1_address_b(b1_ab),
    .layer_former_enable(f_en), .layer_former_reset(f_rst),
    .layer_next_enable(n_en), .layer_next_reset(n_rst),
    .next_bank_sel(sel), .bank_full(full)
  );

  typedef struct {
    logic rst, en, fd, nd;
    logic fr, fe, nr, ne, sel;
    logic [1:0] full;
    logic wp;
  } vec_t;

  typedef struct {
    vec_t v;
    logic [1:0] fr_rd, fr_wr, nx_rd;
    logic [AW-1:0] faa, fab, naa, nab;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  task automatic add(input logic rst, en, fd, nd,
                     input logic fr, fe, nr, ne, s,
                     input logic [1:0] fl, input logic wp);
    vec_t v;
    v.rst = rst; v.en = en; v.fd = fd; v.nd = nd;
    v.fr = fr; v.fe = fe; v.nr = nr; v.ne = ne; v.sel = s;
    v.full = fl; v.wp = wp;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic compare(input int idx, input exp_t e);
    logic [1:0] er [2];
    logic [1:0] ew [2];
    logic [AW-1:0] ea [2];
    logic [AW-1:0] eb [2];
    for (int b = 0; b < 2; b++) begin
      er[b] = '0; ew[b] = '0; ea[b] = '0; eb[b] = '0;
      if (e.v.fe && (e.v.wp == b[0])) begin
        er[b] = e.fr_rd; ew[b] = e.fr_wr;
        ea[b] = e.faa;   eb[b] = e.fab;
      end else if (e.v.ne && (e.v.sel == b[0])) begin
        er[b] = e.nx_rd; ew[b] = 2'b00;
        ea[b] = e.naa;   eb[b] = e.nab;
      end
    end
    chk("former_reset", idx, {31'd0, f_rst}, {31'd0, e.v.fr});
    chk("former_enable", idx, {31'd0, f_en}, {31'd0, e.v.fe});
    chk("next_reset", idx, {31'd0, n_rst}, {31'd0, e.v.nr});
    chk("next_enable", idx, {31'd0, n_en}, {31'd0, e.v.ne});
    chk("next_bank_sel", idx, {31'd0, sel}, {31'd0, e.v.sel});
    chk("bank_full", idx, {30'd0, full}, {30'd0, e.v.full});
    chk("bank0_ctl", idx, {b0_rden, b0_wren, b0_aa, b0_ab},
        {er[0], ew[0], ea[0], eb[0]});
    chk("bank1_ctl", idx, {b1_rden, b1_wren, b1_aa, b1_ab},
        {er[1], ew[1], ea[1], eb[1]});
  endtask

  initial begin
    exp_t e;
    int   waited;
    int   pulses;

    //  rst en fd nd | fr fe nr ne sel full wp
    add(1,0,0,0, 0,0,0,0,0, 2'b00,0); // 0 reset
    add(0,1,0,0, 1,0,0,0,0, 2'b00,0); // 1 former reset pulse
    add(0,1,0,0, 0,1,0,0,0, 2'b00,0); // 2 former runs bank0
    add(0,1,0,0, 0,1,0,0,0, 2'b00,0);
    add(0,1,1,0, 0,0,0,0,0, 2'b01,1); // 4 former done
    add(0,1,1,0, 1,0,1,0,0, 2'b01,1); // 5 both restart
    add(0,1,1,0, 0,1,0,1,0, 2'b01,1); // 6 both run
    add(0,1,1,0, 0,1,0,1,0, 2'b01,1); // 7 held done ignored
    add(0,1,0,0, 0,1,0,1,0, 2'b01,1);
    add(0,1,1,0, 0,0,0,1,0, 2'b11,0); // 9 both full
    add(0,1,1,0, 0,0,0,1,0, 2'b11,0); // 10 former blocked
    add(0,1,0,0, 0,0,0,1,0, 2'b11,0);
    add(0,1,0,1, 0,0,0,0,1, 2'b10,0); // 12 next done
    add(0,1,0,1, 1,0,1,0,1, 2'b10,0); // 13 both restart
    add(0,1,0,1, 0,1,0,1,1, 2'b10,0);
    add(0,1,0,1, 0,1,0,1,1, 2'b10,0); // 15 held done ignored
    add(0,0,0,0, 0,1,0,1,1, 2'b10,0); // 16 enable dropped
    add(0,0,1,0, 0,0,0,1,1, 2'b11,1); // 17 former completes
    add(0,0,0,0, 0,0,0,1,1, 2'b11,1);
    add(0,0,0,1, 0,0,0,0,0, 2'b01,1); // 19 next completes
    add(0,0,0,0, 0,0,0,0,0, 2'b01,1); // 20 no restart
    add(0,0,0,0, 0,0,0,0,0, 2'b01,1);
    add(0,1,0,0, 1,0,1,0,0, 2'b01,1); // 22 enable back
    add(0,1,0,0, 0,1,0,1,0, 2'b01,1);
    add(1,1,0,0, 0,0,0,0,0, 2'b00,0); // 24 reset mid-pass
    add(0,0,0,0, 0,0,0,0,0, 2'b00,0);
    add(0,1,0,1, 1,0,0,0,0, 2'b00,0); // 26 next done in idle
    add(0,1,0,1, 0,1,0,0,0, 2'b00,0);
    add(0,1,1,0, 0,0,0,0,0, 2'b01,1);
    add(0,1,0,0, 1,0,1,0,0, 2'b01,1);
    add(0,1,0,0, 0,1,0,1,0, 2'b01,1);
    add(0,1,1,1, 0,0,0,0,1, 2'b10,0); // 31 set+clear together
    add(0,1,0,0, 1,0,1,0,1, 2'b10,0);
    add(0,1,0,0, 0,1,0,1,1, 2'b10,0);
    add(1,0,0,0, 0,0,0,0,0, 2'b00,0); // 34 reset

    foreach (tbl[i]) begin
      @(negedge clock);
      reset  = tbl[i].rst;
      enable = tbl[i].en;
      fdone  = tbl[i].fd;
      ndone  = tbl[i].nd;
      f_rden = 2'($urandom);
      f_wren = (i % 3 == 0) ? 2'b11 : 2'($urandom);
      n_rden = 2'($urandom);
      f_aa   = (i == 2) ? 9'h005 : AW'($urandom);
      f_ab   = AW'($urandom);
      n_aa   = AW'($urandom);
      n_ab   = AW'($urandom);
      e.v = tbl[i];
      e.fr_rd = f_rden; e.fr_wr = f_wren; e.nx_rd = n_rden;
      e.faa = f_aa; e.fab = f_ab; e.naa = n_aa; e.nab = n_ab;
      sb.push_back(e);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      compare(i, e);
    end

    // Done held high for ten cycles: one bank set, one toggle.
    @(negedge clock);
    reset = 1'b0; enable = 1'b1; fdone = 1'b0; ndone = 1'b0;
    waited = 0;
    while (!f_en && waited < 10) begin
      @(posedge clock); #1;
      waited++;
    end
    chk("start_latency", 0, waited, 2);
    @(negedge clock);
    fdone = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      if (f_rst) pulses++;
      chk("held_done_full", c, {30'd0, full}, 32'd1);
    end
    chk("held_done_restarts", 0, pulses, 1);
    chk("held_done_running", 0, {31'd0, f_en}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
